// File: rtl/padring_iob_mux_ctrl.sv
// Break-before-make sequencer for the IOB/dedicated pad mux selects feeding the padring.
// Optional completed-switch counter enabled by defining PADRING_IOB_MUX_SWITCH_CNT_EN.
module padring_iob_mux_ctrl #(
   parameter int NumIob       = 4,
   parameter int GapCycles    = 4,
   parameter int SettleCycles = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   input  logic [NumIob-1:0] req_sel_i,
   output logic              req_ready_o,
   input  logic              lock_i,
   output logic              locked_o,
   output logic              req_err_o,
   output logic [NumIob-1:0] mux_iob_sel_o,
   output logic [NumIob-1:0] oe_gate_o,
   output logic              busy_o,
   output logic [7:0]        switch_cnt_o
);

   localparam int MaxCnt = (GapCycles > SettleCycles) ? GapCycles : SettleCycles;
   localparam int CntW   = $clog2(MaxCnt + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GATE,
      ST_SWITCH,
      ST_SETTLE
   } state_t;

   state_t              state_reg, state_next;
   logic [CntW-1:0]     cnt_reg, cnt_next;
   logic [NumIob-1:0]   target_reg, target_next;
   logic [NumIob-1:0]   sel_reg, sel_next;
   logic [NumIob-1:0]   gate_reg, gate_next;
   logic                locked_reg, locked_next;
   logic                err_reg, err_next;
   logic                switch_done;
   logic [NumIob-1:0]   mask;

   // Pairs whose select actually flips; only these get their OE gated.
   for (genvar gi = 0; gi < NumIob; gi++) begin : g_mask
      assign mask[gi] = req_sel_i[gi] ^ sel_reg[gi];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         target_reg <= '0;
         sel_reg    <= '0;
         gate_reg   <= '0;
         locked_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         target_reg <= target_next;
         sel_reg    <= sel_next;
         gate_reg   <= gate_next;
         locked_reg <= locked_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      target_next = target_reg;
      sel_next    = sel_reg;
      gate_next   = gate_reg;
      locked_next = locked_reg | lock_i;
      err_next    = 1'b0;
      switch_done = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Lock is registered, so a same-cycle lock_i does not block this request.
            if (req_valid_i) begin
               if (locked_reg) begin
                  err_next = 1'b1;
               end else begin
                  target_next = req_sel_i;
                  if (|mask) begin
                     gate_next  = mask;
                     cnt_next   = CntW'(GapCycles - 1);
                     state_next = ST_GATE;
                  end
               end
            end
         end
         ST_GATE: begin
            if (cnt_reg == '0) begin
               state_next = ST_SWITCH;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_SWITCH: begin
            sel_next   = target_reg;
            cnt_next   = CntW'(SettleCycles - 1);
            state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_reg == '0) begin
               gate_next   = '0;
               switch_done = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            gate_next  = '0;
         end
      endcase
   end

   assign req_ready_o   = (state_reg == ST_IDLE);
   assign busy_o        = (state_reg != ST_IDLE);
   assign locked_o      = locked_reg;
   assign req_err_o     = err_reg;
   assign mux_iob_sel_o = sel_reg;
   assign oe_gate_o     = gate_reg;

`ifdef PADRING_IOB_MUX_SWITCH_CNT_EN
   logic [7:0] switch_cnt_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         switch_cnt_reg <= 8'd0;
      end else if (switch_done && (switch_cnt_reg != 8'hFF)) begin
         switch_cnt_reg <= switch_cnt_reg + 8'd1;
      end
   end

   assign switch_cnt_o = switch_cnt_reg;
`else
   logic unused_switch_done;
   assign unused_switch_done = switch_done;
   assign switch_cnt_o       = 8'd0;
`endif

endmodule

// File: tb/tb_padring_iob_mux_ctrl.sv
// Directed bench for padring_iob_mux_ctrl with default parameters (Gap=4, Settle=2).
module tb_padring_iob_mux_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       req_valid_i;
   logic [3:0] req_sel_i;
   logic       req_ready_o;
   logic       lock_i;
   logic       locked_o;
   logic       req_err_o;
   logic [3:0] mux_iob_sel_o;
   logic [3:0] oe_gate_o;
   logic       busy_o;
   logic [7:0] switch_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;

   padring_iob_mux_ctrl #(
      .NumIob      (4),
      .GapCycles   (4),
      .SettleCycles(2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_sel_i    (req_sel_i),
      .req_ready_o  (req_ready_o),
      .lock_i       (lock_i),
      .locked_o     (locked_o),
      .req_err_o    (req_err_o),
      .mux_iob_sel_o(mux_iob_sel_o),
      .oe_gate_o    (oe_gate_o),
      .busy_o       (busy_o),
      .switch_cnt_o (switch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] exp_cnt(input int n);
`ifdef PADRING_IOB_MUX_SWITCH_CNT_EN
      return 8'(n);
`else
      return 8'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks a full accepted sequence: call right after the acceptance edge (cycle 1);
   // returns at cycle 9 with the FSM back in Idle.
   task automatic run_seq(input string tag, input logic [3:0] mask,
                          input logic [3:0] old_sel, input logic [3:0] new_sel);
      for (int k = 1; k <= 8; k++) begin
         chk({tag, "_gate"}, oe_gate_o, (k <= 7) ? mask : 4'b0000);
         chk({tag, "_sel"}, mux_iob_sel_o, (k >= 6) ? new_sel : old_sel);
         chk({tag, "_busy"}, busy_o, (k <= 7) ? 1'b1 : 1'b0);
         chk({tag, "_ready"}, req_ready_o, (k <= 7) ? 1'b0 : 1'b1);
         $display("%s cycle %0d: gate=%b sel=%b busy=%b", tag, k, oe_gate_o, mux_iob_sel_o, busy_o);
         tick();
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_sel_i   = 4'b0000;
      lock_i      = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;

      // Reset state
      chk("rst_sel", mux_iob_sel_o, 4'b0000);
      chk("rst_gate", oe_gate_o, 4'b0000);
      chk("rst_locked", locked_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_err", req_err_o, 1'b0);
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_cnt", switch_cnt_o, exp_cnt(0));
      $display("reset: sel=%b gate=%b ready=%b", mux_iob_sel_o, oe_gate_o, req_ready_o);

      // First switch 0000 -> 0101
      req_valid_i = 1'b1;
      req_sel_i   = 4'b0101;
      tick();
      req_valid_i = 1'b0;
      req_sel_i   = 4'b1111;
      run_seq("sw1", 4'b0101, 4'b0000, 4'b0101);
      chk("sw1_cnt", switch_cnt_o, exp_cnt(1));

      // Partial change 0101 -> 0110, only low two pairs gated
      req_valid_i = 1'b1;
      req_sel_i   = 4'b0110;
      tick();
      req_valid_i = 1'b0;
      run_seq("sw2", 4'b0011, 4'b0101, 4'b0110);
      chk("sw2_cnt", switch_cnt_o, exp_cnt(2));

      // Null request: consumed without gating
      req_valid_i = 1'b1;
      req_sel_i   = 4'b0110;
      chk("null_ready", req_ready_o, 1'b1);
      tick();
      req_valid_i = 1'b0;
      chk("null_busy", busy_o, 1'b0);
      chk("null_gate", oe_gate_o, 4'b0000);
      tick();
      chk("null_busy2", busy_o, 1'b0);
      chk("null_sel", mux_iob_sel_o, 4'b0110);
      chk("null_cnt", switch_cnt_o, exp_cnt(2));
      $display("null: sel=%b busy=%b", mux_iob_sel_o, busy_o);

      // Valid held through a sequence, request data changing mid-sequence
      req_valid_i = 1'b1;
      req_sel_i   = 4'b0001;
      tick();
      for (int k = 1; k <= 7; k++) begin
         if (k == 3) req_sel_i = 4'b1000;
         chk("hold_ready", req_ready_o, 1'b0);
         chk("hold_gate", oe_gate_o, 4'b0111);
         chk("hold_sel", mux_iob_sel_o, (k >= 6) ? 4'b0001 : 4'b0110);
         $display("hold cycle %0d: ready=%b gate=%b sel=%b", k, req_ready_o, oe_gate_o, mux_iob_sel_o);
         tick();
      end
      chk("hold_ready_back", req_ready_o, 1'b1);
      chk("hold_sel_done", mux_iob_sel_o, 4'b0001);
      chk("hold_gate_off", oe_gate_o, 4'b0000);
      tick();
      req_valid_i = 1'b0;
      run_seq("hold2", 4'b1001, 4'b0001, 4'b1000);
      chk("hold_cnt", switch_cnt_o, exp_cnt(4));

      // Lock, then a rejected request
      lock_i = 1'b1;
      tick();
      lock_i = 1'b0;
      chk("lock_set", locked_o, 1'b1);
      chk("lock_busy", busy_o, 1'b0);
      req_valid_i = 1'b1;
      req_sel_i   = 4'b1111;
      chk("lock_ready", req_ready_o, 1'b1);
      tick();
      req_valid_i = 1'b0;
      chk("lock_err", req_err_o, 1'b1);
      chk("lock_sel", mux_iob_sel_o, 4'b1000);
      chk("lock_nobusy", busy_o, 1'b0);
      chk("lock_nogate", oe_gate_o, 4'b0000);
      tick();
      chk("lock_err_once", req_err_o, 1'b0);
      lock_i = 1'b1;
      tick();
      lock_i = 1'b0;
      tick();
      chk("lock_again", locked_o, 1'b1);
      chk("lock_again_sel", mux_iob_sel_o, 4'b1000);
      chk("lock_cnt", switch_cnt_o, exp_cnt(4));
      $display("lock: locked=%b err=%b sel=%b", locked_o, req_err_o, mux_iob_sel_o);

      // Only reset clears the lock
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk("unlock", locked_o, 1'b0);
      chk("unlock_sel", mux_iob_sel_o, 4'b0000);
      $display("unlock: locked=%b sel=%b", locked_o, mux_iob_sel_o);

      // Lock and valid in the same Idle cycle: request still accepted
      req_valid_i = 1'b1;
      req_sel_i   = 4'b0011;
      lock_i      = 1'b1;
      tick();
      req_valid_i = 1'b0;
      lock_i      = 1'b0;
      chk("lv_busy", busy_o, 1'b1);
      chk("lv_locked", locked_o, 1'b1);
      chk("lv_gate", oe_gate_o, 4'b0011);
      chk("lv_err", req_err_o, 1'b0);
      for (int k = 0; k < 7; k++) tick();
      chk("lv_sel", mux_iob_sel_o, 4'b0011);
      chk("lv_done", busy_o, 1'b0);
      $display("lock+valid: sel=%b locked=%b", mux_iob_sel_o, locked_o);

      // Reset mid-Gate aborts with no retained gating
      rst_ni = 1'b0;
      tick();
      rst_ni      = 1'b1;
      req_valid_i = 1'b1;
      req_sel_i   = 4'b1100;
      tick();
      req_valid_i = 1'b0;
      tick();
      chk("abort_pre_gate", oe_gate_o, 4'b1100);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk("abort_gate", oe_gate_o, 4'b0000);
      chk("abort_sel", mux_iob_sel_o, 4'b0000);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_ready", req_ready_o, 1'b1);
      chk("abort_cnt", switch_cnt_o, exp_cnt(0));
      $display("abort: gate=%b sel=%b busy=%b ready=%b", oe_gate_o, mux_iob_sel_o, busy_o, req_ready_o);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
